// File: rtl/dcache_port_arbiter.sv
// N-to-1 arbiter for the split-phase data-cache port: round-robin index phase,
// owner-tracked tag phase, and a port-ID FIFO that routes in-order read responses.
module dcache_port_arbiter #(
    parameter int NrPorts        = 3,
    parameter int IndexWidth     = 12,
    parameter int TagWidth       = 44,
    parameter int DataWidth      = 64,
    parameter int MaxOutstanding = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NrPorts-1:0][IndexWidth-1:0]   slv_address_index_i,
    input  logic [NrPorts-1:0][TagWidth-1:0]     slv_address_tag_i,
    input  logic [NrPorts-1:0][DataWidth-1:0]    slv_data_wdata_i,
    input  logic [NrPorts-1:0][DataWidth/8-1:0]  slv_data_be_i,
    input  logic [NrPorts-1:0]                   slv_data_we_i,
    input  logic [NrPorts-1:0]                   slv_data_req_i,
    input  logic [NrPorts-1:0]                   slv_kill_req_i,
    input  logic [NrPorts-1:0]                   slv_tag_valid_i,
    output logic [NrPorts-1:0]                   slv_data_gnt_o,
    output logic [NrPorts-1:0]                   slv_data_rvalid_o,
    output logic [DataWidth-1:0]                 slv_data_rdata_o,
    output logic [IndexWidth-1:0]                mst_address_index_o,
    output logic [TagWidth-1:0]                  mst_address_tag_o,
    output logic [DataWidth-1:0]                 mst_data_wdata_o,
    output logic [DataWidth/8-1:0]               mst_data_be_o,
    output logic                                 mst_data_we_o,
    output logic                                 mst_data_req_o,
    output logic                                 mst_kill_req_o,
    output logic                                 mst_tag_valid_o,
    input  logic                                 mst_data_gnt_i,
    input  logic                                 mst_data_rvalid_i,
    input  logic [DataWidth-1:0]                 mst_data_rdata_i,
    output logic                                 err_unexpected_rvalid_o
);

    localparam int PortIdW = $clog2(NrPorts);
    localparam int PtrW    = $clog2(MaxOutstanding);
    localparam int CntW    = PtrW + 1;

    typedef logic [PortIdW-1:0] port_id_t;

    port_id_t            rr_q;
    port_id_t            owner_q;
    logic                owner_we_q;
    logic                tag_pending_q;
    port_id_t            fifo_q [MaxOutstanding];
    logic [PtrW-1:0]     rd_ptr_q;
    logic [PtrW-1:0]     wr_ptr_q;
    logic [CntW-1:0]     count_q;
    logic                err_q;

    logic                full;
    logic [NrPorts-1:0]  eligible;
    port_id_t            winner;
    logic                found;
    int                  idx;
    logic                any_req;
    logic                accept;
    logic                push;
    logic                pop;
    port_id_t            head;

    // A pending tag-phase read already holds a slot, so it counts toward the limit.
    always_comb begin
        full     = (int'(count_q) + ((tag_pending_q && !owner_we_q) ? 1 : 0)) >= MaxOutstanding;
        eligible = slv_data_req_i & (slv_data_we_i | {NrPorts{~full}});
    end

    // NOTE: every variable assigned in a combinational block gets a default first,
    // otherwise an unassigned path infers a latch.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NrPorts; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NrPorts) idx = idx - NrPorts;
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = port_id_t'(idx);
            end
        end
    end

    assign any_req = rst_ni && found;
    assign accept  = any_req && mst_data_gnt_i;
    assign push    = tag_pending_q && slv_tag_valid_i[owner_q] && !slv_kill_req_i[owner_q]
                     && !owner_we_q;
    assign pop     = rst_ni && mst_data_rvalid_i && (count_q != '0);
    assign head    = fifo_q[rd_ptr_q];

    assign mst_data_req_o      = any_req;
    assign mst_address_index_o = slv_address_index_i[winner];
    assign mst_data_wdata_o    = slv_data_wdata_i[winner];
    assign mst_data_be_o       = slv_data_be_i[winner];
    assign mst_data_we_o       = slv_data_we_i[winner];

    assign mst_address_tag_o   = slv_address_tag_i[owner_q];
    assign mst_tag_valid_o     = tag_pending_q && slv_tag_valid_i[owner_q];
    assign mst_kill_req_o      = tag_pending_q && slv_kill_req_i[owner_q];

    assign slv_data_rdata_o        = mst_data_rdata_i;
    assign err_unexpected_rvalid_o = err_q;

    always_comb begin
        slv_data_gnt_o    = '0;
        slv_data_rvalid_o = '0;
        if (accept) slv_data_gnt_o[winner] = 1'b1;
        if (pop)    slv_data_rvalid_o[head] = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q          <= '0;
            owner_q       <= '0;
            owner_we_q    <= 1'b0;
            tag_pending_q <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            err_q         <= 1'b0;
        end else begin
            if (accept) begin
                rr_q       <= (int'(winner) == NrPorts - 1) ? '0 : winner + port_id_t'(1);
                owner_q    <= winner;
                owner_we_q <= slv_data_we_i[winner];
            end
            tag_pending_q <= accept;
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
            if (mst_data_rvalid_i && count_q == '0) err_q <= 1'b1;
        end
    end

    // NOTE: FIFO storage has no reset; the pointers and count define which
    // entries are valid, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= owner_q;
    end

endmodule
